// File: rtl/qa_drv_umf_pkg.sv
// Shared UMF types and header-field helpers for the RX unpack path.
// Header chunk layout: [LEN_LSB +: LEN_W] body-chunk count,
// [SERV_LSB +: SERV_W] service, [CHAN_LSB +: CHAN_W] channel.
package qa_drv_umf_pkg;

  localparam int UMF_CHUNK_W  = 128;
  localparam int UMF_CHAN_W   = 8;
  localparam int UMF_SERV_W   = 8;
  localparam int UMF_LEN_W    = 12;
  localparam int UMF_LEN_LSB  = 0;
  localparam int UMF_SERV_LSB = 12;
  localparam int UMF_CHAN_LSB = 20;

  typedef logic [UMF_CHUNK_W-1:0] t_UMF_CHUNK;

  typedef enum logic {
    RX_HDR  = 1'b0,
    RX_BODY = 1'b1
  } t_UMF_RX_STATE;

  typedef struct packed {
    t_UMF_CHUNK            data;
    logic                  sop;
    logic                  eop;
    logic [UMF_CHAN_W-1:0] chan;
    logic [UMF_SERV_W-1:0] serv;
  } t_UMF_BEAT;

  function automatic logic [UMF_LEN_W-1:0] umf_hdr_len(input t_UMF_CHUNK c, input int unsigned lsb);
    return c[lsb +: UMF_LEN_W];
  endfunction

  function automatic logic [UMF_CHAN_W-1:0] umf_hdr_chan(input t_UMF_CHUNK c, input int unsigned lsb);
    return c[lsb +: UMF_CHAN_W];
  endfunction

  function automatic logic [UMF_SERV_W-1:0] umf_hdr_serv(input t_UMF_CHUNK c, input int unsigned lsb);
    return c[lsb +: UMF_SERV_W];
  endfunction

endpackage

// File: rtl/qa_drv_skid_fifo2.sv
// Two-entry beat FIFO decoupling the parser from the downstream demux.
// notFull is derived from the registered count only, so the upstream
// enable never depends combinationally on the consumer's ready.
module qa_drv_skid_fifo2
  import qa_drv_umf_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      enq_en,
  input  t_UMF_BEAT enq_data,
  output logic      notFull,
  input  logic      deq_en,
  output logic      notEmpty,
  output t_UMF_BEAT first
);

  t_UMF_BEAT  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Control: pointers and occupancy, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (enq_en) r_wr_ptr <= ~r_wr_ptr;
      if (deq_en) r_rd_ptr <= ~r_rd_ptr;
      case ({enq_en, deq_en})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage: payload written on enqueue, no reset needed
  always_ff @(posedge clk) begin
    if (enq_en) r_mem[r_wr_ptr] <= enq_data;
  end

  assign notFull  = (r_count != 2'd2);
  assign notEmpty = (r_count != 2'd0);
  assign first    = r_mem[r_rd_ptr];

endmodule

// File: rtl/qa_drv_umf_rx_unpack.sv
// UMF RX unpacker: parses header/body chunk boundaries from the FIFO
// driver stream and emits sop/eop/channel-tagged beats through a
// 2-entry buffer. Optional statistics counters are built only when
// QA_DRV_UMF_RX_STATS_EN is defined; otherwise they read as zero.
module qa_drv_umf_rx_unpack
  import qa_drv_umf_pkg::*;
#(
  parameter int UMF_WIDTH  = UMF_CHUNK_W,
  parameter int CHAN_WIDTH = UMF_CHAN_W,
  parameter int SERV_WIDTH = UMF_SERV_W,
  parameter int LEN_WIDTH  = UMF_LEN_W,
  parameter int LEN_LSB    = UMF_LEN_LSB,
  parameter int SERV_LSB   = UMF_SERV_LSB,
  parameter int CHAN_LSB   = UMF_CHAN_LSB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [UMF_WIDTH-1:0]  in_data,
  input  logic                  in_rdy,
  output logic                  in_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [UMF_WIDTH-1:0]  out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [CHAN_WIDTH-1:0] out_chan,
  output logic [SERV_WIDTH-1:0] out_serv,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_chunks
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  t_UMF_RX_STATE         r_state;
  t_UMF_RX_STATE         w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  w_remaining_nxt;
  logic [CHAN_WIDTH-1:0] r_chan;
  logic [CHAN_WIDTH-1:0] w_chan_nxt;
  logic [SERV_WIDTH-1:0] r_serv;
  logic [SERV_WIDTH-1:0] w_serv_nxt;

  logic [LEN_WIDTH-1:0]  w_hdr_len;
  logic [CHAN_WIDTH-1:0] w_hdr_chan;
  logic [SERV_WIDTH-1:0] w_hdr_serv;

  t_UMF_BEAT w_beat;
  t_UMF_BEAT w_first;
  logic      w_not_full;
  logic      w_not_empty;
  logic      w_pop;

  assign w_hdr_len  = umf_hdr_len(in_data, LEN_LSB);
  assign w_hdr_chan = umf_hdr_chan(in_data, CHAN_LSB);
  assign w_hdr_serv = umf_hdr_serv(in_data, SERV_LSB);

  // Dequeue decision uses only the registered buffer count
  assign in_enable = in_rdy && w_not_full && !reset;
  assign w_pop     = w_not_empty && out_ready;

  // Parser state register: header/body phase and body countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RX_HDR;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Packet identity latched from the header for the body beats
  always_ff @(posedge clk) begin
    r_chan <= w_chan_nxt;
    r_serv <= w_serv_nxt;
  end

  // Next-state and beat tagging for the chunk at the head of the stream
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_chan_nxt      = r_chan;
    w_serv_nxt      = r_serv;
    w_beat.data     = in_data;
    w_beat.sop      = 1'b0;
    w_beat.eop      = 1'b0;
    w_beat.chan     = r_chan;
    w_beat.serv     = r_serv;
    case (r_state)
      RX_HDR: begin
        w_beat.sop  = 1'b1;
        w_beat.chan = w_hdr_chan;
        w_beat.serv = w_hdr_serv;
        w_beat.eop  = (w_hdr_len == '0);
        if (in_enable) begin
          w_chan_nxt = w_hdr_chan;
          w_serv_nxt = w_hdr_serv;
          if (w_hdr_len != '0) begin
            w_remaining_nxt = w_hdr_len;
            w_state_nxt     = RX_BODY;
          end
        end
      end
      RX_BODY: begin
        w_beat.eop = (r_remaining == LEN_ONE);
        if (in_enable) begin
          w_remaining_nxt = r_remaining - LEN_ONE;
          if (r_remaining == LEN_ONE) w_state_nxt = RX_HDR;
        end
      end
      default: w_state_nxt = RX_HDR;
    endcase
  end

  // Stage boundary: tagged beat enters the output buffer
  qa_drv_skid_fifo2 u_obuf (
    .clk      (clk),
    .reset    (reset),
    .enq_en   (in_enable),
    .enq_data (w_beat),
    .notFull  (w_not_full),
    .deq_en   (w_pop),
    .notEmpty (w_not_empty),
    .first    (w_first)
  );

  assign out_valid = w_not_empty;
  assign out_data  = w_not_empty ? w_first.data : '0;
  assign out_sop   = w_not_empty && w_first.sop;
  assign out_eop   = w_not_empty && w_first.eop;
  assign out_chan  = w_not_empty ? w_first.chan : '0;
  assign out_serv  = w_not_empty ? w_first.serv : '0;

`ifdef QA_DRV_UMF_RX_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_chunks;

  // Completed-packet and consumed-chunk counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_pkts   <= '0;
      r_stat_chunks <= '0;
    end else if (in_enable) begin
      r_stat_chunks <= r_stat_chunks + 32'd1;
      if (w_beat.eop) r_stat_pkts <= r_stat_pkts + 32'd1;
    end
  end

  assign stat_pkts   = r_stat_pkts;
  assign stat_chunks = r_stat_chunks;
`else
  assign stat_pkts   = '0;
  assign stat_chunks = '0;
`endif

endmodule

// File: tb/tb_qa_drv_umf_rx_unpack.sv
// Directed bench for qa_drv_umf_rx_unpack; statistics expectations
// follow QA_DRV_UMF_RX_STATS_EN.
module tb_qa_drv_umf_rx_unpack;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data;
  logic         in_rdy;
  logic         in_enable;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_sop;
  logic         out_eop;
  logic [7:0]   out_chan;
  logic [7:0]   out_serv;
  logic [31:0]  stat_pkts;
  logic [31:0]  stat_chunks;

  always #5 clk = ~clk;

  qa_drv_umf_rx_unpack dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .in_enable   (in_enable),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_chan    (out_chan),
    .out_serv    (out_serv),
    .stat_pkts   (stat_pkts),
    .stat_chunks (stat_chunks)
  );

  typedef struct {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [7:0]   chan;
    logic [7:0]   serv;
    int           cyc;
  } beat_t;

  beat_t        got_q[$];
  logic [127:0] src_q[$];
  logic [127:0] exp_q[$];
  int           deq_cyc_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int deq_cnt = 0;
  int en_viol = 0;
  int stall = 0;
  bit tog_en = 0;
  bit tog = 1;
  bit rdy_def = 1;
  int exp_pk;
  int exp_ch;

  function automatic logic [127:0] hdr(input logic [7:0] c, input logic [7:0] s, input logic [11:0] l);
    return {96'hC0DE_0000_1111_2222_3333_4444, 4'hA, c, s, l};
  endfunction

  function automatic logic [127:0] body(input int i);
    return {32'(i), 96'h5A5A_A5A5_0F0F_F0F0_1234_5678};
  endfunction

  task automatic drive();
    if (tog_en) tog = ~tog; else tog = 1'b1;
    in_rdy  = (src_q.size() > 0) && tog;
    in_data = (src_q.size() > 0) ? src_q[0] : '0;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = rdy_def;
    end
  endtask

  task automatic step();
    logic  deq;
    beat_t b;
    @(negedge clk);
    if (in_enable && !in_rdy) en_viol++;
    deq = in_enable;
    if (deq) begin
      deq_cnt++;
      deq_cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready && !reset) begin
      b.data = out_data; b.sop = out_sop; b.eop = out_eop;
      b.chan = out_chan; b.serv = out_serv; b.cyc = cyc;
      got_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (deq && src_q.size() > 0) src_q.delete(0);
    cyc++;
    drive();
  endtask

  task automatic clear_logs();
    got_q.delete();
    deq_cyc_q.delete();
    exp_q.delete();
    deq_cnt = 0;
    en_viol = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_q.delete();
    drive();
    step();
    step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic load(input logic [127:0] c);
    src_q.push_back(c);
    exp_q.push_back(c);
  endtask

  task automatic set_stat_exp(input int pk, input int ch);
`ifdef QA_DRV_UMF_RX_STATS_EN
    exp_pk = pk; exp_ch = ch;
`else
    exp_pk = 0 * pk; exp_ch = 0 * ch;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; in_rdy = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    src_q.push_back(hdr(8'h01, 8'h01, 12'd0));
    drive();
    @(negedge clk);
    n_tests++; if (in_enable !== 1'b0) begin n_fail++; $display("FAIL reset_in_enable got=%b exp=0", in_enable); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if ({out_sop, out_eop} !== 2'b00) begin n_fail++; $display("FAIL reset_sop_eop got=%b exp=00", {out_sop, out_eop}); end
    n_tests++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_tests++; if ({out_chan, out_serv} !== 16'h0) begin n_fail++; $display("FAIL reset_chan_serv got=%h exp=0", {out_chan, out_serv}); end
    n_tests++; if ({stat_pkts, stat_chunks} !== 64'd0) begin n_fail++; $display("FAIL reset_stats got=%h exp=0", {stat_pkts, stat_chunks}); end
    @(posedge clk); #1;
    reset = 1'b0;
    src_q.delete();
    drive();
    clear_logs();
  endtask

  task automatic test_len0();
    do_reset();
    load(hdr(8'h05, 8'h02, 12'd0));
    drive();
    repeat (4) step();
    n_tests++;
    if (got_q.size() != 1 || deq_cnt != 1) begin
      n_fail++; $display("FAIL len0_count beats=%0d deqs=%0d exp=1/1", got_q.size(), deq_cnt);
    end else begin
      n_tests++;
      if ({got_q[0].sop, got_q[0].eop, got_q[0].chan, got_q[0].serv} !== {1'b1, 1'b1, 8'h05, 8'h02}) begin
        n_fail++; $display("FAIL len0_tags got=%b%b/%h/%h exp=11/05/02", got_q[0].sop, got_q[0].eop, got_q[0].chan, got_q[0].serv);
      end
      n_tests++; if (got_q[0].data !== exp_q[0]) begin n_fail++; $display("FAIL len0_data got=%h exp=%h", got_q[0].data, exp_q[0]); end
      n_tests++; if (got_q[0].cyc != deq_cyc_q[0] + 1) begin n_fail++; $display("FAIL len0_latency got=%0d exp=%0d", got_q[0].cyc - deq_cyc_q[0], 1); end
    end
  endtask

  task automatic test_len3();
    do_reset();
    load(hdr(8'h11, 8'h22, 12'd3));
    for (int i = 1; i <= 3; i++) load(body(i));
    drive();
    repeat (8) step();
    n_tests++;
    if (got_q.size() != 4) begin
      n_fail++; $display("FAIL len3_count got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if ({got_q[i].sop, got_q[i].eop, got_q[i].chan, got_q[i].serv} !== {(i == 0), (i == 3), 8'h11, 8'h22}) begin
          n_fail++; $display("FAIL len3_tags[%0d] got=%b%b/%h/%h exp=%b%b/11/22", i, got_q[i].sop, got_q[i].eop, got_q[i].chan, got_q[i].serv, (i == 0), (i == 3));
        end
        n_tests++; if (got_q[i].data !== exp_q[i]) begin n_fail++; $display("FAIL len3_data[%0d] got=%h exp=%h", i, got_q[i].data, exp_q[i]); end
        n_tests++; if (got_q[i].cyc != got_q[0].cyc + i) begin n_fail++; $display("FAIL len3_consecutive[%0d] got=%0d exp=%0d", i, got_q[i].cyc, got_q[0].cyc + i); end
      end
    end
    set_stat_exp(1, 4);
    n_tests++; if (stat_pkts !== 32'(exp_pk)) begin n_fail++; $display("FAIL len3_stat_pkts got=%0d exp=%0d", stat_pkts, exp_pk); end
    n_tests++; if (stat_chunks !== 32'(exp_ch)) begin n_fail++; $display("FAIL len3_stat_chunks got=%0d exp=%0d", stat_chunks, exp_ch); end
  endtask

  task automatic test_stall();
    int unstable;
    unstable = 0;
    do_reset();
    load(hdr(8'h11, 8'h22, 12'd3));
    for (int i = 1; i <= 3; i++) load(body(i));
    stall = 6;
    drive();
    repeat (5) begin
      step();
      if (out_valid && out_data !== exp_q[0]) unstable++;
    end
    n_tests++; if (deq_cnt != 2) begin n_fail++; $display("FAIL stall_deq_count got=%0d exp=2", deq_cnt); end
    n_tests++; if (in_enable !== 1'b0) begin n_fail++; $display("FAIL stall_in_enable got=%b exp=0", in_enable); end
    n_tests++; if ({out_valid, out_sop, out_eop} !== 3'b110) begin n_fail++; $display("FAIL stall_head_tags got=%b exp=110", {out_valid, out_sop, out_eop}); end
    n_tests++; if (unstable != 0 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", out_data, exp_q[0]); end
    repeat (10) step();
    n_tests++;
    if (got_q.size() != 4) begin
      n_fail++; $display("FAIL stall_beats got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if ({got_q[i].data, got_q[i].sop, got_q[i].eop} !== {exp_q[i], (i == 0), (i == 3)}) begin
          n_fail++; $display("FAIL stall_order[%0d] got=%h/%b%b exp=%h/%b%b", i, got_q[i].data, got_q[i].sop, got_q[i].eop, exp_q[i], (i == 0), (i == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ch;
    do_reset();
    load(hdr(8'h33, 8'h01, 12'd1));
    load(body(7));
    load(hdr(8'h44, 8'h02, 12'd1));
    load(body(8));
    tog_en = 1'b1; tog = 1'b0;
    drive();
    repeat (14) step();
    tog_en = 1'b0;
    n_tests++; if (en_viol != 0) begin n_fail++; $display("FAIL b2b_enable_without_rdy got=%0d exp=0", en_viol); end
    n_tests++;
    if (got_q.size() != 4 || deq_cyc_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_count beats=%0d deqs=%0d exp=4/4", got_q.size(), deq_cyc_q.size());
    end else begin
      n_tests++; if (deq_cyc_q[3] - deq_cyc_q[0] != 6) begin n_fail++; $display("FAIL b2b_deq_spacing got=%0d exp=6", deq_cyc_q[3] - deq_cyc_q[0]); end
      for (int i = 0; i < 4; i++) begin
        ch = (i < 2) ? 8'h33 : 8'h44;
        n_tests++;
        if ({got_q[i].sop, got_q[i].eop, got_q[i].chan} !== {(i % 2 == 0), (i % 2 == 1), ch}) begin
          n_fail++; $display("FAIL b2b_tags[%0d] got=%b%b/%h exp=%b%b/%h", i, got_q[i].sop, got_q[i].eop, got_q[i].chan, (i % 2 == 0), (i % 2 == 1), ch);
        end
      end
    end
  endtask

  task automatic test_maxlen();
    int n_eop;
    int n_sop;
    do_reset();
    load(hdr(8'h07, 8'h01, 12'd4095));
    for (int i = 1; i <= 4095; i++) load(body(i));
    load(hdr(8'h0A, 8'h03, 12'd0));
    drive();
    repeat (4110) step();
    n_tests++;
    if (got_q.size() != 4097) begin
      n_fail++; $display("FAIL maxlen_count got=%0d exp=4097", got_q.size());
    end else begin
      n_eop = 0; n_sop = 0;
      for (int i = 0; i < 4096; i++) begin
        n_eop += int'(got_q[i].eop);
        n_sop += int'(got_q[i].sop);
      end
      n_tests++; if (n_eop != 1 || got_q[4095].eop !== 1'b1) begin n_fail++; $display("FAIL maxlen_eop count=%0d last=%b exp=1/1", n_eop, got_q[4095].eop); end
      n_tests++; if (n_sop != 1 || got_q[0].sop !== 1'b1) begin n_fail++; $display("FAIL maxlen_sop count=%0d exp=1", n_sop); end
      n_tests++; if (got_q[4095].data !== body(4095) || got_q[4095].chan !== 8'h07) begin n_fail++; $display("FAIL maxlen_last got=%h/%h exp=%h/07", got_q[4095].data, got_q[4095].chan, body(4095)); end
      n_tests++;
      if ({got_q[4096].sop, got_q[4096].eop, got_q[4096].chan, got_q[4096].serv} !== {1'b1, 1'b1, 8'h0A, 8'h03}) begin
        n_fail++; $display("FAIL maxlen_next_hdr got=%b%b/%h/%h exp=11/0a/03", got_q[4096].sop, got_q[4096].eop, got_q[4096].chan, got_q[4096].serv);
      end
    end
    set_stat_exp(2, 4097);
    n_tests++; if ({stat_pkts, stat_chunks} !== {32'(exp_pk), 32'(exp_ch)}) begin n_fail++; $display("FAIL maxlen_stats got=%0d/%0d exp=%0d/%0d", stat_pkts, stat_chunks, exp_pk, exp_ch); end
  endtask

  task automatic test_mid_reset();
    int k;
    do_reset();
    load(hdr(8'h21, 8'h01, 12'd5));
    for (int i = 1; i <= 5; i++) load(body(i));
    drive();
    k = 0;
    while (deq_cnt < 3 && k < 20) begin
      step();
      k++;
    end
    n_tests++; if (deq_cnt != 3) begin n_fail++; $display("FAIL midrst_reach_body2 got=%0d exp=3", deq_cnt); end
    rdy_def = 1'b0;
    drive();
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
    reset = 1'b1;
    src_q.delete();
    drive();
    step();
    reset = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_cleared got=%b exp=0", out_valid); end
    clear_logs();
    rdy_def = 1'b1;
    load(hdr(8'h09, 8'h04, 12'd0));
    drive();
    repeat (4) step();
    n_tests++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_count got=%0d exp=1", got_q.size());
    end else begin
      n_tests++;
      if ({got_q[0].sop, got_q[0].eop, got_q[0].chan, got_q[0].serv} !== {1'b1, 1'b1, 8'h09, 8'h04}) begin
        n_fail++; $display("FAIL midrst_hdr got=%b%b/%h/%h exp=11/09/04", got_q[0].sop, got_q[0].eop, got_q[0].chan, got_q[0].serv);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_rdy = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_len0();
    test_len3();
    test_stall();
    test_back_to_back();
    test_maxlen();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
